gc_controller_poller: RTL
=========================

// Module: gc_controller_poller
// PURPOSE
//  - Initiator side of the single-wire GameCube controller link on one gpio pin.
//  - Every poll period it transmits the 24-bit poll command, then receives the
//    controller's 64-bit status reply.
//  - Presents the last good reply as a stable 64-bit word for the mmio block to read.
//  - One instance is used per player.
// PARAMETERS
//  CLK_PER_US      50    clock cycles per microsecond (50 MHz board clock)
//  POLL_PERIOD_US  1000  interval between poll starts, in us
//  RESP_TIMEOUT_US 60    maximum wait from end of stop bit to the first reply falling edge
//  BIT_TIMEOUT_US  6     maximum wait between successive reply falling edges
// PORTS
//  clock          in   1   system clock
//  reset          in   1   asynchronous, active-low reset
//  poll_en        in   1   1 = periodic polling allowed
//  line_in        in   1   raw pin level (asynchronous, pulled up externally)
//  line_oe        out  1   1 = drive pin low; 0 = release (open drain)
//  buttons        out  64  last good reply, bit 63 = first bit received
//  buttons_valid  out  1   one-cycle pulse when buttons updates
//  rx_error       out  1   set on timeout; cleared by next good frame
//  busy           out  1   high in every state except IDLE
//  rumble         in   1   (RUMBLE_EN only) rumble request
// BEHAVIOUR
//  - Reset (asynchronous, mid-frame included):
//    - line_oe=0 immediately; buttons=0, buttons_valid=0, rx_error=0, busy=0.
//    - FSM goes to IDLE; poll timer is cleared.
//  - line_in passes through a 2-flop synchronizer. A falling edge is sync==0 with prior sync==1.
//  - Poll timer counts POLL_PERIOD_US*CLK_PER_US cycles, free-running.
//    - At wrap with poll_en=1 in IDLE: go to TX_BIT.
//    - At wrap with the FSM not in IDLE: ignore the wrap; no queued poll.
//  - TX_BIT: 24 command bits, MSB first. Command is 24'h400300.
//    - Each bit cell is 4 us.
//    - '0' bit: line_oe=1 for 3 us, then 0 for 1 us.
//    - '1' bit: line_oe=1 for 1 us, then 0 for 3 us.
//    - Cells are back-to-back, with no gap cycles.
//  - TX_STOP: line_oe=1 for 1 us, then release. Go to RX_WAIT.
//    - From then on, line_oe stays 0 until the next poll.
//  - RX_WAIT: wait for a falling edge.
//    - If RESP_TIMEOUT_US elapses first: rx_error=1, go to IDLE. buttons is unchanged.
//  - RX_BIT: on each falling edge, wait 2*CLK_PER_US cycles, then sample the
//    synchronized line (low=0, high=1). Shift the sample in at the LSB.
//    - Then wait for the next falling edge, with BIT_TIMEOUT_US timeout.
//    - A timeout mid-frame sets rx_error, discards the partial word, and returns to IDLE.
//  - After the 64th sample: copy the shift register to buttons, pulse buttons_valid
//    for 1 cycle, clear rx_error, go to RX_END.
//  - RX_END: wait until the line has been high for 4 us (controller stop bit done),
//    then go to IDLE.
//  - Latency from poll-timer wrap to buttons_valid is about 100 us + 64*4 us, set by the controller.
//  - poll_en falling mid-frame does not abort the frame; it only blocks the next start.
//  - Counter widths come from $clog2 of the largest product; none wrap inside a state.
// CONFIGURATION
//  RUMBLE_EN defined:
//    - The command LSB equals rumble, sampled at TX_BIT entry (24'h400301 when rumble=1).
//  RUMBLE_EN undefined:
//    - There is no rumble port; the command is constant 24'h400300.
// STRUCTURE
//  gc_pkg:
//    - state enum: IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, RX_END.
//    - GC_POLL_CMD, GC_CMD_BITS=24, GC_RESP_BITS=64.
//    - Cell lengths in us: CELL=4, SHORT=1, LONG=3, SAMPLE=2.
//  gc_line_sync sub-module: 2-flop synchronizer plus falling-edge detector.
//    - Outputs: sync, fall.
//  The FSM, timers and shift registers stay in gc_controller_poller.
// TESTING (CLK_PER_US=4, POLL_PERIOD_US=400)
//  - Reset release, poll_en=1: first poll starts after 1600 cycles.
//    - line_oe shows 24 cells of 16 cycles, then a 4-cycle stop.
//    - Decoded low-times match 0x400300 (0 bit = 12 cycles low, 1 bit = 4 cycles low).
//  - Controller model replies with 64'h0080_8080_8080_0000 after 8 us:
//    - buttons equals that value; one buttons_valid pulse; rx_error=0.
//  - No reply (line held high):
//    - rx_error=1 after 240 cycles of RX_WAIT; buttons keeps its old value; busy=0 afterwards.
//  - Model stops after 30 bits:
//    - rx_error=1 after 24 idle cycles; no buttons_valid.
//    - Next full reply clears rx_error.
//  - reset asserted mid-TX_BIT while line_oe=1:
//    - line_oe=0 in the same cycle; all outputs 0.
//    - After release, the first poll starts 1600 cycles later.
//  - RUMBLE_EN with rumble=1: last command cell is 4 cycles low (0x400301).
//    - poll_en=0 at timer wrap: no line activity.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared types and constants for the GameCube controller poller.
package gc_pkg;

  // Poller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_STOP,
    RX_WAIT,
    RX_BIT,
    RX_END
  } gc_state_e;

  localparam int GC_CMD_BITS  = 24;
  localparam int GC_RESP_BITS = 64;
  localparam logic [GC_CMD_BITS-1:0] GC_POLL_CMD = 24'h400300;

  // Bit-cell timing, in microseconds.
  localparam int GC_CELL_US   = 4;
  localparam int GC_SHORT_US  = 1;
  localparam int GC_LONG_US   = 3;
  localparam int GC_SAMPLE_US = 2;

  // Larger of two integers; used to size the shared state counter.
  function automatic int gc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the raw controller pin plus a falling-edge detector.
module gc_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the pin and keep one cycle of history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: flops reset to 1 (idle line level) so leaving reset never fakes a falling edge.
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/gc_controller_poller.sv
// Initiator for the single-wire GameCube controller link: periodically sends the
// 24-bit poll command and captures the 64-bit status reply.
// Optional build macro RUMBLE_EN adds i_rumble, which sets the command LSB.
module gc_controller_poller
  import gc_pkg::*;
#(
  parameter int CLK_PER_US      = 50,
  parameter int POLL_PERIOD_US  = 1000,
  parameter int RESP_TIMEOUT_US = 60,
  parameter int BIT_TIMEOUT_US  = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
`ifdef RUMBLE_EN
  input  logic                    i_rumble,
`endif
  input  logic                    i_poll_en,
  input  logic                    i_line_in,
  output logic                    o_line_oe,
  output logic [GC_RESP_BITS-1:0] o_buttons,
  output logic                    o_buttons_valid,
  output logic                    o_rx_error,
  output logic                    o_busy
);

  localparam int POLL_CYC    = POLL_PERIOD_US * CLK_PER_US;
  localparam int CELL_CYC    = GC_CELL_US * CLK_PER_US;
  localparam int SHORT_CYC   = GC_SHORT_US * CLK_PER_US;
  localparam int LONG_CYC    = GC_LONG_US * CLK_PER_US;
  localparam int SAMPLE_CYC  = GC_SAMPLE_US * CLK_PER_US;
  localparam int RESP_TO_CYC = RESP_TIMEOUT_US * CLK_PER_US;
  localparam int BIT_TO_CYC  = BIT_TIMEOUT_US * CLK_PER_US;

  localparam int POLL_W = $clog2(POLL_CYC);
  localparam int CNT_W  = $clog2(gc_max(gc_max(CELL_CYC, RESP_TO_CYC), BIT_TO_CYC));
  localparam int TX_W   = $clog2(GC_CMD_BITS);
  localparam int RX_W   = $clog2(GC_RESP_BITS);

  localparam logic [POLL_W-1:0] POLL_LAST   = POLL_W'(POLL_CYC - 1);
  localparam logic [CNT_W-1:0]  CELL_LAST   = CNT_W'(CELL_CYC - 1);
  localparam logic [CNT_W-1:0]  SHORT_LAST  = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0]  RESP_LAST   = CNT_W'(RESP_TO_CYC - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST    = CNT_W'(BIT_TO_CYC - 1);
  localparam logic [TX_W-1:0]   TX_LAST     = TX_W'(GC_CMD_BITS - 1);
  localparam logic [RX_W-1:0]   RX_LAST     = RX_W'(GC_RESP_BITS - 1);

  gc_state_e                r_state;
  logic [POLL_W-1:0]        r_poll_cnt;
  logic [CNT_W-1:0]         r_cnt;
  logic [TX_W-1:0]          r_tx_idx;
  logic [RX_W-1:0]          r_rx_idx;
  logic [GC_CMD_BITS-1:0]   r_tx_sh;
  logic [GC_RESP_BITS-2:0]  r_rx_sh;
  logic                     r_sampled;
  logic                     r_line_oe;
  logic [GC_RESP_BITS-1:0]  r_buttons;
  logic                     r_valid;
  logic                     r_rx_error;

  logic                     w_sync;
  logic                     w_fall;
  logic                     w_poll_wrap;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic [CNT_W-1:0]         w_low_len;
  logic [GC_CMD_BITS-1:0]   w_cmd;

  gc_line_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_line_in),
    .o_sync  (w_sync),
    .o_fall  (w_fall)
  );

`ifdef RUMBLE_EN
  assign w_cmd = {GC_POLL_CMD[GC_CMD_BITS-1:1], i_rumble};
`else
  assign w_cmd = GC_POLL_CMD;
`endif

  assign w_poll_wrap = (r_poll_cnt == POLL_LAST);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  // A '1' bit is a short low pulse, a '0' bit a long one.
  assign w_low_len   = r_tx_sh[GC_CMD_BITS-1] ? CNT_W'(SHORT_CYC) : CNT_W'(LONG_CYC);

  // Free-running poll period timer; wraps regardless of FSM state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_poll_cnt <= '0;
    end else if (w_poll_wrap) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + POLL_W'(1);
    end
  end

  // Frame sequencer: transmit command, receive reply, publish result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tx_idx   <= '0;
      r_rx_idx   <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_sampled  <= 1'b0;
      r_line_oe  <= 1'b0;
      r_buttons  <= '0;
      r_valid    <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_line_oe <= 1'b0;
          if (w_poll_wrap && i_poll_en) begin
            r_state   <= TX_BIT;
            r_cnt     <= '0;
            r_tx_idx  <= '0;
            r_tx_sh   <= w_cmd;
            r_line_oe <= 1'b1;
          end
        end
        TX_BIT: begin
          if (r_cnt == CELL_LAST) begin
            r_cnt     <= '0;
            r_line_oe <= 1'b1;
            r_tx_sh   <= r_tx_sh << 1;
            if (r_tx_idx == TX_LAST) begin
              r_state <= TX_STOP;
            end else begin
              r_tx_idx <= r_tx_idx + TX_W'(1);
            end
          end else begin
            r_cnt     <= w_cnt_inc;
            r_line_oe <= (w_cnt_inc < w_low_len);
          end
        end
        TX_STOP: begin
          if (r_cnt == SHORT_LAST) begin
            r_line_oe <= 1'b0;
            r_cnt     <= '0;
            r_state   <= RX_WAIT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RX_WAIT: begin
          if (w_fall) begin
            r_state   <= RX_BIT;
            r_cnt     <= '0;
            r_rx_idx  <= '0;
            r_sampled <= 1'b0;
          end else if (r_cnt == RESP_LAST) begin
            r_rx_error <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RX_BIT: begin
          // The counter runs from the falling edge, covering both sample point and bit timeout.
          if (!r_sampled) begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == SAMPLE_LAST) begin
              r_rx_sh   <= {r_rx_sh[GC_RESP_BITS-3:0], w_sync};
              r_sampled <= 1'b1;
              if (r_rx_idx == RX_LAST) begin
                r_buttons  <= {r_rx_sh, w_sync};
                r_valid    <= 1'b1;
                r_rx_error <= 1'b0;
                r_cnt      <= '0;
                r_state    <= RX_END;
              end else begin
                r_rx_idx <= r_rx_idx + RX_W'(1);
              end
            end
          end else if (w_fall) begin
            r_cnt     <= '0;
            r_sampled <= 1'b0;
          end else if (r_cnt == BIT_LAST) begin
            r_rx_error <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RX_END: begin
          // Leave only after the line has stayed high for one full cell.
          if (!w_sync) begin
            r_cnt <= '0;
          end else if (r_cnt == CELL_LAST) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_line_oe <= 1'b0;
        end
      endcase
    end
  end

  assign o_line_oe       = r_line_oe;
  assign o_buttons       = r_buttons;
  assign o_buttons_valid = r_valid;
  assign o_rx_error      = r_rx_error;
  assign o_busy          = (r_state != IDLE);

endmodule
